// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage.
//   - 3-bit op select encodings driven by the ALU result mux
//   - flag bit positions within the 4-bit {N,Z,C,V} flag vector
//   - occupancy states of the two-entry output skid buffer
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned FLAG_W = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational N/Z/C/V derivation for one ALU result.
//   result_i   : selected ALU result
//   sel_i      : op select that produced result_i
//   carry_i    : adder carry-out
//   overflow_i : adder signed overflow
//   flags_o    : {N,Z,C,V}; C and V are forced low for non-arithmetic ops
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter logic [7:0]  ARITH_MASK = 8'b0000_0011
) (
  input  logic [WIDTH-1:0] result_i,
  input  logic [2:0]       sel_i,
  input  logic             carry_i,
  input  logic             overflow_i,
  output logic [3:0]       flags_o
);

  logic is_arith;

  always_comb begin
    is_arith        = ARITH_MASK[sel_i];
    flags_o         = '0;
    flags_o[FLAG_N] = result_i[WIDTH-1];
    flags_o[FLAG_Z] = (result_i == '0);
    flags_o[FLAG_C] = carry_i & is_arith;
    flags_o[FLAG_V] = overflow_i & is_arith;
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind the ALU result mux.
// Captures {result, op, N, Z, C, V} into a two-entry skid buffer and hands
// the head entry to writeback over valid/ready. ready_o decodes only the
// state register, so there is no combinational path from ready_i.
//   clk_i, rst_i               : clock, synchronous active-high reset
//   result_i/sel_i/carry_i/
//   overflow_i/valid_i/ready_o : upstream handshake
//   result_o/op_o/flags_o/
//   valid_o/ready_i            : downstream handshake (head entry)
//   clr_sticky_i/sticky_ovf_o  : sticky arithmetic overflow
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter logic [7:0]  ARITH_MASK = 8'b0000_0011
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] result_i,
  input  logic [2:0]       sel_i,
  input  logic             carry_i,
  input  logic             overflow_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] result_o,
  output logic [2:0]       op_o,
  output logic [3:0]       flags_o,
  output logic             valid_o,
  input  logic             ready_i,
  input  logic             clr_sticky_i,
  output logic             sticky_ovf_o
);

  localparam int unsigned ENTRY_W = WIDTH + OP_W + FLAG_W;

  skid_state_t        state_q, state_d;
  logic [ENTRY_W-1:0] main_q, main_d;
  logic [ENTRY_W-1:0] skid_q, skid_d;
  logic               sticky_q, sticky_d;

  logic [3:0]         new_flags;
  logic [ENTRY_W-1:0] new_entry;
  logic               in_xfer;
  logic               out_xfer;

  alu_flag_gen #(
    .WIDTH      (WIDTH),
    .ARITH_MASK (ARITH_MASK)
  ) u_flag_gen (
    .result_i   (result_i),
    .sel_i      (sel_i),
    .carry_i    (carry_i),
    .overflow_i (overflow_i),
    .flags_o    (new_flags)
  );

  assign new_entry    = {result_i, sel_i, new_flags};
  assign valid_o      = (state_q != ST_EMPTY);
  assign ready_o      = (state_q != ST_FULL);
  assign in_xfer      = valid_i & ready_o;
  assign out_xfer     = valid_o & ready_i;
  assign result_o     = main_q[ENTRY_W-1 -: WIDTH];
  assign op_o         = main_q[FLAG_W +: OP_W];
  assign flags_o      = main_q[FLAG_W-1:0];
  assign sticky_ovf_o = sticky_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_d  = new_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = new_entry;
        end else if (in_xfer) begin
          skid_d  = new_entry;
          state_d = ST_FULL;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // ready_o is low here, so only a drain can happen
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // A new overflow outranks a simultaneous clear
  always_comb begin
    sticky_d = sticky_q;
    if (in_xfer && new_flags[FLAG_V]) begin
      sticky_d = 1'b1;
    end else if (clr_sticky_i) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios followed by
// randomized traffic, checked against a queue-based reference model.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] result_i;
  logic [2:0]  sel_i;
  logic        carry_i;
  logic        overflow_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] result_o;
  logic [2:0]  op_o;
  logic [3:0]  flags_o;
  logic        valid_o;
  logic        ready_i;
  logic        clr_sticky_i;
  logic        sticky_ovf_o;

  always #5 clk = ~clk;

  alu_result_stage #(
    .WIDTH      (32),
    .ARITH_MASK (8'b0000_0011)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .result_i     (result_i),
    .sel_i        (sel_i),
    .carry_i      (carry_i),
    .overflow_i   (overflow_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .result_o     (result_o),
    .op_o         (op_o),
    .flags_o      (flags_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .clr_sticky_i (clr_sticky_i),
    .sticky_ovf_o (sticky_ovf_o)
  );

  typedef struct {
    logic [31:0] res;
    logic [2:0]  op;
    logic [3:0]  flg;
  } exp_entry_t;

  exp_entry_t  mq[$];
  logic        m_sticky;
  int unsigned passed = 0;
  int unsigned total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Flags from first principles: only ADD and SUB report carry/overflow.
  function automatic exp_entry_t make_entry(input logic [31:0] r, input logic [2:0] s,
                                            input logic c, input logic v);
    exp_entry_t e;
    logic arith;
    arith = (s == 3'd0) || (s == 3'd1);
    e.res = r;
    e.op  = s;
    e.flg = {r[31], (r == 32'd0), c && arith, v && arith};
    return e;
  endfunction

  // One clock: predict the handshakes from the model's occupancy, advance,
  // then compare everything the DUT exposes.
  task automatic step();
    bit         do_in, do_out;
    exp_entry_t e;
    do_in  = valid_i && (mq.size() < 2);
    do_out = (mq.size() > 0) && ready_i;
    e      = make_entry(result_i, sel_i, carry_i, overflow_i);
    @(posedge clk);
    #1;
    if (rst_i) begin
      mq.delete();
      m_sticky = 1'b0;
    end else begin
      if (do_out) void'(mq.pop_front());
      if (do_in) mq.push_back(e);
      if (do_in && e.flg[0]) m_sticky = 1'b1;
      else if (clr_sticky_i) m_sticky = 1'b0;
    end
    check("valid_o", {31'd0, valid_o}, {31'd0, mq.size() > 0});
    check("ready_o", {31'd0, ready_o}, {31'd0, mq.size() < 2});
    check("sticky", {31'd0, sticky_ovf_o}, {31'd0, m_sticky});
    if (mq.size() > 0) begin
      check("result_o", result_o, mq[0].res);
      check("op_o", {29'd0, op_o}, {29'd0, mq[0].op});
      check("flags_o", {28'd0, flags_o}, {28'd0, mq[0].flg});
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [2:0] s,
                       input logic c, input logic o);
    valid_i    = v;
    result_i   = r;
    sel_i      = s;
    carry_i    = c;
    overflow_i = o;
  endtask

  initial begin
    m_sticky     = 1'b0;
    rst_i        = 1'b1;
    ready_i      = 1'b1;
    clr_sticky_i = 1'b0;
    drive(1'b0, 32'd0, 3'd0, 1'b0, 1'b0);

    // Reset for two cycles
    step();
    step();
    rst_i = 1'b0;
    check("rst_result", result_o, 32'd0);
    check("rst_op", {29'd0, op_o}, 32'd0);
    check("rst_flags", {28'd0, flags_o}, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_ready", {31'd0, ready_o}, 32'd1);

    // Single transfer, zero result, logical op
    drive(1'b1, 32'd0, 3'b010, 1'b1, 1'b1);
    step();
    check("single_flags", {28'd0, flags_o}, 32'h4);
    check("single_op", {29'd0, op_o}, 32'h2);
    drive(1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
    step();

    // Arithmetic flags, then a non-arithmetic op with the same adder outputs
    drive(1'b1, 32'h8000_0000, 3'b000, 1'b1, 1'b1);
    step();
    check("arith_flags", {28'd0, flags_o}, 32'hb);
    check("arith_sticky", {31'd0, sticky_ovf_o}, 32'd1);
    drive(1'b1, 32'h8000_0000, 3'b101, 1'b1, 1'b1);
    step();
    check("logic_flags", {28'd0, flags_o}, 32'h8);
    check("logic_sticky", {31'd0, sticky_ovf_o}, 32'd1);
    drive(1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
    clr_sticky_i = 1'b1;
    step();
    clr_sticky_i = 1'b0;
    step();

    // Backpressure fills both entries; the third offer must wait
    ready_i = 1'b0;
    drive(1'b1, 32'h11, 3'b011, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h22, 3'b011, 1'b0, 1'b0);
    step();
    check("bp_ready", {31'd0, ready_o}, 32'd0);
    check("bp_head", result_o, 32'h11);
    drive(1'b1, 32'h33, 3'b011, 1'b0, 1'b0);
    step();
    check("bp_hold", result_o, 32'h11);
    drive(1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
    ready_i = 1'b1;
    step();
    check("bp_second", result_o, 32'h22);
    step();
    check("bp_drained", {31'd0, valid_o}, 32'd0);

    // Full-rate streaming
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 32'h100 + i, 3'(i % 8), 1'b0, 1'b0);
      step();
      check("stream_data", result_o, 32'h100 + i);
    end
    drive(1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
    step();

    // Set and clear in the same cycle: set wins
    clr_sticky_i = 1'b1;
    drive(1'b1, 32'h7fff_ffff, 3'b001, 1'b0, 1'b1);
    step();
    check("collide_sticky", {31'd0, sticky_ovf_o}, 32'd1);
    drive(1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
    step();
    check("clear_sticky", {31'd0, sticky_ovf_o}, 32'd0);
    clr_sticky_i = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0 ? 32'd0 : $urandom,
            3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
      ready_i      = $urandom_range(0, 2) != 0;
      clr_sticky_i = $urandom_range(0, 5) == 0;
      step();
    end
    clr_sticky_i = 1'b0;

    // Reset while full, with a pending overflow already recorded
    ready_i = 1'b1;
    drive(1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
    step();
    step();
    ready_i = 1'b0;
    drive(1'b1, 32'haa, 3'b000, 1'b0, 1'b1);
    step();
    drive(1'b1, 32'hbb, 3'b000, 1'b0, 1'b0);
    step();
    check("pre_rst_full", {31'd0, ready_o}, 32'd0);
    rst_i = 1'b1;
    drive(1'b1, 32'hcc, 3'b000, 1'b1, 1'b1);
    step();
    rst_i = 1'b0;
    check("midrst_valid", {31'd0, valid_o}, 32'd0);
    check("midrst_ready", {31'd0, ready_o}, 32'd1);
    check("midrst_sticky", {31'd0, sticky_ovf_o}, 32'd0);
    drive(1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_stale", {31'd0, valid_o}, 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
